// File: rtl/ping_pong_frame_reader_pkg.sv
// Shared types and defaults for the ping-pong buffer frame reader.
package ping_pong_frame_reader_pkg;

  localparam int unsigned FrameLenDef = 256;
  localparam int unsigned AddrWDef    = 8;
  localparam int unsigned DataWDef    = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StGap
  } state_e;

  typedef struct packed {
    logic [DataWDef-1:0] cha;
    logic [DataWDef-1:0] chb;
    logic                last;
  } beat_t;

endpackage

// File: rtl/frame_beat_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; read data reads as zero when empty.
module frame_beat_fifo #(
  parameter int unsigned Width = 129,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [Width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [Width-1:0]           rd_data,
  output logic                       valid,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop     = rd_en && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a write.
  assign push    = wr_en && ((count_q != CntW'(Depth)) || pop);
  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign rd_data = valid ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ping_pong_frame_reader.sv
// Reads one frame per ready pulse from the ping-pong buffer and streams paired CHA/CHB beats,
// issuing reads only while the output FIFO has credit for every outstanding return.
module ping_pong_frame_reader
  import ping_pong_frame_reader_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = FrameLenDef,
  parameter int unsigned ADDR_W      = AddrWDef,
  parameter int unsigned DATA_W      = DataWDef,
  parameter int unsigned OFIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_start_ready,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   cha_data,
  input  logic                cha_valid,
  input  logic                cha_last,
  input  logic [DATA_W-1:0]   chb_data,
  input  logic                chb_valid,
  input  logic                chb_last,
  output logic [2*DATA_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                frame_overrun,
  output logic                chan_mismatch
);

  localparam int unsigned BeatW    = 2 * DATA_W + 1;
  localparam int unsigned CntW     = $clog2(OFIFO_DEPTH + 1);
  localparam int unsigned GapW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned BeatCntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_e              state_q;
  logic [1:0]          pending_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [GapW-1:0]     gap_q;
  logic                inflight_q;
  logic                overrun_q;
  logic                mismatch_q;
  logic [BeatCntW-1:0] beat_cnt_q;

  logic [CntW-1:0]     ofifo_count;
  logic [CntW:0]       credit_used;
  logic                credit_ok;
  logic                have_work, gap_done, frame_start, last_read;
  logic                beat_wr, exp_last, beat_bad, fifo_pop;
  logic [BeatW-1:0]    fifo_wdata, fifo_rdata;

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------
  assign have_work   = (pending_q != 2'd0) || rd_start_ready;
  assign gap_done    = (state_q == StGap) && (gap_q == GapW'(GAP_CYCLES - 1));
  assign frame_start = have_work && ((state_q == StIdle) || gap_done);

  // A read issued last cycle has not landed in the FIFO yet but already owns a slot.
  assign credit_used = {1'b0, ofifo_count} + {{CntW{1'b0}}, inflight_q};
  assign credit_ok   = credit_used < (CntW + 1)'(OFIFO_DEPTH);

  assign rd_en     = (state_q == StRead) && credit_ok;
  assign rd_addr   = (state_q == StRead) ? addr_q : '0;
  assign last_read = rd_en && (addr_q == ADDR_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      gap_q      <= '0;
      pending_q  <= 2'd0;
      overrun_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;

      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q <= StRead;
          end
        end
        StRead: begin
          if (last_read) begin
            addr_q  <= '0;
            gap_q   <= '0;
            state_q <= StGap;
          end else if (rd_en) begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        StGap: begin
          if (gap_done) begin
            state_q <= frame_start ? StRead : StIdle;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      if (rd_start_ready && !frame_start) begin
        if (pending_q == 2'd2) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= pending_q + 2'd1;
        end
      end else if (!rd_start_ready && frame_start) begin
        pending_q <= pending_q - 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return path
  // ---------------------------------------------------------------------------
  assign beat_wr  = cha_valid || chb_valid;
  assign exp_last = (beat_cnt_q == BeatCntW'(FRAME_LEN - 1));
  assign beat_bad = (cha_valid != chb_valid)
                 || (beat_wr && (cha_last != chb_last))
                 || (cha_valid && (cha_last != exp_last))
                 || (chb_valid && (chb_last != exp_last));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (beat_wr) begin
        beat_cnt_q <= exp_last ? '0 : beat_cnt_q + BeatCntW'(1);
      end
      if (beat_bad) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  // Framing comes from our own beat count; the channel last flags are only cross-checked.
  assign fifo_wdata = {cha_data, chb_data, exp_last};
  assign fifo_pop   = m_tvalid && m_tready;

  frame_beat_fifo #(
    .Width(BeatW),
    .Depth(OFIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (beat_wr),
    .wr_data(fifo_wdata),
    .rd_en  (fifo_pop),
    .rd_data(fifo_rdata),
    .valid  (m_tvalid),
    .count  (ofifo_count)
  );

  assign m_tdata       = fifo_rdata[BeatW-1:1];
  assign m_tlast       = fifo_rdata[0];
  assign frame_overrun = overrun_q;
  assign chan_mismatch = mismatch_q;

endmodule
